// File: rtl/pwq_pkg.sv
// pwq_pkg: shared definitions for the piecewise-quadratic activation unit.
//   - pwq_seg_e       : input segment selected from the effective argument xe
//   - pwq_tanh_coef() : real-valued tanh coefficients (c0, c1, c2) per segment
//   - pwq_quant()     : quantises a real coefficient to round(c * 2^frac_w)
// Both functions are evaluated at elaboration time only.
package pwq_pkg;

    typedef enum logic [2:0] {
        SAT_NEG = 3'd0,
        SEG0    = 3'd1,
        SEG1    = 3'd2,
        SEG2    = 3'd3,
        SEG3    = 3'd4,
        SAT_POS = 3'd5
    } pwq_seg_e;

    // seg: 0..3 = SEG0..SEG3, k: 0..2 = c0..c2
    function automatic real pwq_tanh_coef(input int seg, input int k);
        real c;
        c = 0.0;
        case (seg * 3 + k)
            0:  c = -0.39814608;
            1:  c =  0.46527859;
            2:  c =  0.09007576;
            3:  c =  0.0031444;
            4:  c =  1.08381219;
            5:  c =  0.31592922;
            6:  c = -0.00349517;
            7:  c =  1.08538355;
            8:  c = -0.31676793;
            9:  c =  0.39878032;
            10: c =  0.46509003;
            11: c = -0.09013554;
            default: c = 0.0;
        endcase
        return c;
    endfunction

    // Round to nearest, ties away from zero.
    function automatic int pwq_quant(input real c, input int frac_w);
        real s;
        s = c * $itor(1 << frac_w);
        if (s >= 0.0) return $rtoi(s + 0.5);
        else          return -$rtoi(-s + 0.5);
    endfunction

endpackage

// File: rtl/pwq_seg_select.sv
// pwq_seg_select: combinational segment compare and coefficient mux (stage S1).
// Ports:
//   i_xe   signed effective argument (x, or x/2 for sigmoid), FRAC_W fraction bits
//   o_seg  selected segment
//   o_c0..o_c2  quantised coefficients for that segment
// Boundaries are strict on the lower side: each segment is (lo, hi].
module pwq_seg_select
    import pwq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic signed [DATA_W-1:0] i_xe,
    output pwq_seg_e                 o_seg,
    output logic signed [DATA_W-1:0] o_c0,
    output logic signed [DATA_W-1:0] o_c1,
    output logic signed [DATA_W-1:0] o_c2
);

    localparam logic signed [DATA_W-1:0] ONE       = DATA_W'(1 << FRAC_W);
    localparam logic signed [DATA_W-1:0] NEG_ONE   = -ONE;
    localparam logic signed [DATA_W-1:0] THREE     = DATA_W'(3 << FRAC_W);
    localparam logic signed [DATA_W-1:0] NEG_THREE = -THREE;

    localparam logic signed [DATA_W-1:0] C0_S0 = DATA_W'(pwq_quant(pwq_tanh_coef(0, 0), FRAC_W));
    localparam logic signed [DATA_W-1:0] C1_S0 = DATA_W'(pwq_quant(pwq_tanh_coef(0, 1), FRAC_W));
    localparam logic signed [DATA_W-1:0] C2_S0 = DATA_W'(pwq_quant(pwq_tanh_coef(0, 2), FRAC_W));
    localparam logic signed [DATA_W-1:0] C0_S1 = DATA_W'(pwq_quant(pwq_tanh_coef(1, 0), FRAC_W));
    localparam logic signed [DATA_W-1:0] C1_S1 = DATA_W'(pwq_quant(pwq_tanh_coef(1, 1), FRAC_W));
    localparam logic signed [DATA_W-1:0] C2_S1 = DATA_W'(pwq_quant(pwq_tanh_coef(1, 2), FRAC_W));
    localparam logic signed [DATA_W-1:0] C0_S2 = DATA_W'(pwq_quant(pwq_tanh_coef(2, 0), FRAC_W));
    localparam logic signed [DATA_W-1:0] C1_S2 = DATA_W'(pwq_quant(pwq_tanh_coef(2, 1), FRAC_W));
    localparam logic signed [DATA_W-1:0] C2_S2 = DATA_W'(pwq_quant(pwq_tanh_coef(2, 2), FRAC_W));
    localparam logic signed [DATA_W-1:0] C0_S3 = DATA_W'(pwq_quant(pwq_tanh_coef(3, 0), FRAC_W));
    localparam logic signed [DATA_W-1:0] C1_S3 = DATA_W'(pwq_quant(pwq_tanh_coef(3, 1), FRAC_W));
    localparam logic signed [DATA_W-1:0] C2_S3 = DATA_W'(pwq_quant(pwq_tanh_coef(3, 2), FRAC_W));

    always_comb begin
        o_seg = SEG1;
        o_c0  = C0_S1;
        o_c1  = C1_S1;
        o_c2  = C2_S1;
        if (i_xe <= NEG_THREE) begin
            // Saturated: constant output, polynomial terms forced to zero
            o_seg = SAT_NEG;
            o_c0  = NEG_ONE;
            o_c1  = '0;
            o_c2  = '0;
        end else if (i_xe <= NEG_ONE) begin
            o_seg = SEG0;
            o_c0  = C0_S0;
            o_c1  = C1_S0;
            o_c2  = C2_S0;
        end else if (i_xe <= 0) begin
            o_seg = SEG1;
            o_c0  = C0_S1;
            o_c1  = C1_S1;
            o_c2  = C2_S1;
        end else if (i_xe <= ONE) begin
            o_seg = SEG2;
            o_c0  = C0_S2;
            o_c1  = C1_S2;
            o_c2  = C2_S2;
        end else if (i_xe <= THREE) begin
            o_seg = SEG3;
            o_c0  = C0_S3;
            o_c1  = C1_S3;
            o_c2  = C2_S3;
        end else begin
            o_seg = SAT_POS;
            o_c0  = ONE;
            o_c1  = '0;
            o_c2  = '0;
        end
    end

endmodule

// File: rtl/pwq_activation.sv
// pwq_activation: pipelined piecewise-quadratic tanh / sigmoid unit.
// sigmoid(x) = 0.5 + 0.5*tanh(x/2), sharing the tanh tables.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready       input handshake; in_data (signed Q.FRAC_W), in_mode
//                           (0 tanh, 1 sigmoid), in_tag (returned unchanged)
//   out_valid/out_ready     output handshake; out_data (signed Q.FRAC_W), out_tag
// Handshake: a word moves when valid && ready on a rising edge. The whole
// pipeline advances when the output register is empty or being consumed, so
// in_ready = !out_valid || out_ready; out_data/out_tag hold while stalled.
// Stages: S1 segment/coeff, S2 square and linear term, S3 quadratic term,
// S4 sum+clamp, then the output register (sigmoid scaling) -> 4-edge latency.
// Build option: define PWQ_ROUND_EN to round half up in the product scaling
// instead of truncating.
module pwq_activation
    import pwq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int TAG_W  = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_mode,
    input  logic        [TAG_W-1:0]  in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic        [TAG_W-1:0]  out_tag
);

    localparam int PW = 2 * DATA_W;
    localparam int TW = DATA_W + 2;
`ifdef PWQ_ROUND_EN
    localparam logic signed [PW-1:0] RND = PW'(1 << (FRAC_W - 1));
`else
    localparam logic signed [PW-1:0] RND = '0;
`endif
    localparam logic signed [TW-1:0]     T_MAX = TW'(1 << FRAC_W);
    localparam logic signed [TW-1:0]     T_MIN = -T_MAX;
    localparam logic signed [DATA_W-1:0] HALF  = DATA_W'(1 << (FRAC_W - 1));

    logic w_advance;
    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;

    // S1
    logic signed [DATA_W-1:0] w_xe, w_c0, w_c1, w_c2;
    pwq_seg_e                 w_seg;
    assign w_xe = in_mode ? (in_data >>> 1) : in_data;

    pwq_seg_select #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_seg (
        .i_xe (w_xe),
        .o_seg(w_seg),
        .o_c0 (w_c0),
        .o_c1 (w_c1),
        .o_c2 (w_c2)
    );

    logic                     r1_valid, r1_mode;
    logic        [TAG_W-1:0]  r1_tag;
    logic signed [DATA_W-1:0] r1_xe, r1_c0, r1_c1, r1_c2;

    // S2
    logic signed [PW-1:0] w_xe_ext, w_c1_ext, w_sq_prod, w_p1_prod;
    assign w_xe_ext  = {{DATA_W{r1_xe[DATA_W-1]}}, r1_xe};
    assign w_c1_ext  = {{DATA_W{r1_c1[DATA_W-1]}}, r1_c1};
    assign w_sq_prod = (w_xe_ext * w_xe_ext + RND) >>> FRAC_W;
    assign w_p1_prod = (w_c1_ext * w_xe_ext + RND) >>> FRAC_W;

    logic                     r2_valid, r2_mode;
    logic        [TAG_W-1:0]  r2_tag;
    logic signed [DATA_W-1:0] r2_sq, r2_p1, r2_c0, r2_c2;

    // S3
    logic signed [PW-1:0] w_c2_ext, w_sq_ext, w_p2_prod;
    assign w_c2_ext  = {{DATA_W{r2_c2[DATA_W-1]}}, r2_c2};
    assign w_sq_ext  = {{DATA_W{r2_sq[DATA_W-1]}}, r2_sq};
    assign w_p2_prod = (w_c2_ext * w_sq_ext + RND) >>> FRAC_W;

    logic                     r3_valid, r3_mode;
    logic        [TAG_W-1:0]  r3_tag;
    logic signed [DATA_W-1:0] r3_c0, r3_p1, r3_p2;

    // S4: two guard bits keep the three-term sum from wrapping before the clamp
    logic signed [TW-1:0] w_t, w_t_clamp;
    assign w_t = {{2{r3_c0[DATA_W-1]}}, r3_c0}
               + {{2{r3_p1[DATA_W-1]}}, r3_p1}
               + {{2{r3_p2[DATA_W-1]}}, r3_p2};
    assign w_t_clamp = (w_t > T_MAX) ? T_MAX : ((w_t < T_MIN) ? T_MIN : w_t);

    logic                     r4_valid, r4_mode;
    logic        [TAG_W-1:0]  r4_tag;
    logic signed [DATA_W-1:0] r4_t;

    // Output stage
    logic signed [DATA_W-1:0] w_out;
    assign w_out = r4_mode ? (HALF + (r4_t >>> 1)) : r4_t;

    always_ff @(posedge clock) begin
        if (reset) begin
            r1_valid  <= 1'b0;
            r2_valid  <= 1'b0;
            r3_valid  <= 1'b0;
            r4_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
        end else if (w_advance) begin
            r1_valid <= in_valid;
            r1_mode  <= in_mode;
            r1_tag   <= in_tag;
            r1_xe    <= w_xe;
            r1_c0    <= w_c0;
            r1_c1    <= w_c1;
            r1_c2    <= w_c2;

            r2_valid <= r1_valid;
            r2_mode  <= r1_mode;
            r2_tag   <= r1_tag;
            r2_sq    <= w_sq_prod[DATA_W-1:0];
            r2_p1    <= w_p1_prod[DATA_W-1:0];
            r2_c0    <= r1_c0;
            r2_c2    <= r1_c2;

            r3_valid <= r2_valid;
            r3_mode  <= r2_mode;
            r3_tag   <= r2_tag;
            r3_c0    <= r2_c0;
            r3_p1    <= r2_p1;
            r3_p2    <= w_p2_prod[DATA_W-1:0];

            r4_valid <= r3_valid;
            r4_mode  <= r3_mode;
            r4_tag   <= r3_tag;
            r4_t     <= w_t_clamp[DATA_W-1:0];

            out_valid <= r4_valid;
            out_data  <= w_out;
            out_tag   <= r4_tag;
        end
    end

    // Upper product bits and the segment id are intentionally not consumed
    logic w_unused;
    assign w_unused = ^{w_sq_prod, w_p1_prod, w_p2_prod, w_t_clamp, w_seg};

endmodule

// File: tb/tb_pwq_activation.sv
module tb_pwq_activation;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int TAG_W  = 4;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic              in_valid  = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data   = '0;
  logic              in_mode   = 1'b0;
  logic [TAG_W-1:0]  in_tag    = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;

  pwq_activation #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // scoreboard
  logic [TAG_W+DATA_W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int out_cyc[$];

  // streaming vectors: even = tanh, odd = sigmoid; hand-computed results
  logic [15:0] st_x[16] = '{16'h0100, 16'h0000, 16'h0400, 16'h0800,
                            16'hFC00, 16'hF800, 16'hFD00, 16'h0200,
                            16'h0000, 16'hFE00, 16'h0080, 16'h0100,
                            16'hFF80, 16'hFF00, 16'h0200, 16'h0600};
  logic [15:0] st_e[16] = '{16'h00C4, 16'h0080, 16'h0100, 16'h0100,
                            16'hFF00, 16'h0000, 16'hFF00, 16'h00E2,
                            16'h0001, 16'h001D, 16'h0075, 16'h00BA,
                            16'hFF8A, 16'h0045, 16'h00F8, 16'h00FE};

  // directed singles: {mode, x, expected}
  logic [32:0] dir_v[9] = '{{1'b0, 16'h0400, 16'h0100},
                            {1'b0, 16'hFC00, 16'hFF00},
                            {1'b0, 16'hFD00, 16'hFF00},
                            {1'b0, 16'h0000, 16'h0001},
                            {1'b0, 16'h0300, 16'h00FC},
                            {1'b0, 16'hFF00, 16'hFF3A},
                            {1'b1, 16'h0000, 16'h0080},
                            {1'b1, 16'h0800, 16'h0100},
                            {1'b1, 16'hF800, 16'h0000}};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // monitor: samples 2 time units after the falling edge
  logic              stall_prev = 1'b0;
  logic [DATA_W-1:0] held_data;
  logic [TAG_W-1:0]  held_tag;
  initial begin
    logic [TAG_W+DATA_W-1:0] e;
    forever begin
      @(negedge clock);
      #2;
      if (reset) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev && out_valid) begin
          check("hold_data", out_data, held_data);
          check("hold_tag", out_tag, held_tag);
        end
        if (out_valid && !out_ready) begin
          check("in_ready_stall", in_ready, 0);
          held_data  = out_data;
          held_tag   = out_tag;
          stall_prev = 1'b1;
        end else begin
          stall_prev = 1'b0;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out: got tag %0d data 0x%0h, required no output", out_tag, out_data);
          end else begin
            e = exp_q.pop_front();
            check("out_tag", out_tag, e[TAG_W+DATA_W-1:DATA_W]);
            check("out_data", out_data, e[DATA_W-1:0]);
            out_cyc.push_back(cyc);
          end
        end
      end
    end
  end

  // driver: called at a falling edge, returns at a falling edge with in_valid=0
  task automatic send(input logic [15:0] x, input logic m, input logic [TAG_W-1:0] t,
                      input logic [15:0] e, input logic push);
    int guard;
    logic acc;
    if (push) exp_q.push_back({t, e});
    in_valid = 1'b1;
    in_data  = x;
    in_mode  = m;
    in_tag   = t;
    guard = 0;
    acc   = 1'b0;
    while (!acc && guard < 100) begin
      #1 acc = in_ready;
      @(posedge clock);
      if (!acc) begin
        guard++;
        @(negedge clock);
      end
    end
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got no in_ready in %0d cycles, required accept", guard);
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, required 0", exp_q.size());
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic measure_latency(input string name);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check(name, lat, 4);
  endtask

  initial begin
    int base;
    // reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    reset = 1'b0;
    @(negedge clock);
    check("rst_in_ready", in_ready, 1);

    // first transaction and its latency
    send(16'h0100, 1'b0, 4'd1, 16'h00C4, 1'b1);
    measure_latency("latency");
    drain();

    // directed boundaries, back-to-back
    for (int i = 0; i < 9; i++)
      send(dir_v[i][31:16], dir_v[i][32], TAG_W'(i + 2), dir_v[i][15:0], 1'b1);
    drain();

    // streaming at full rate
    base = out_cyc.size();
    for (int i = 0; i < 16; i++)
      send(st_x[i], i[0], TAG_W'(i), st_e[i], 1'b1);
    drain();
    check("stream_count", out_cyc.size() - base, 16);
    if (out_cyc.size() - base == 16)
      check("stream_rate", out_cyc[base + 15] - out_cyc[base], 15);

    // back-pressure mid-stream
    base = out_cyc.size();
    fork
      begin
        for (int i = 0; i < 16; i++)
          send(st_x[15 - i], ~i[0], TAG_W'(15 - i), st_e[15 - i], 1'b1);
      end
      begin
        repeat (6) @(negedge clock);
        out_ready = 1'b0;
        repeat (6) @(negedge clock);
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", out_cyc.size() - base, 16);

    // reset with three samples in flight
    send(16'h0100, 1'b0, 4'hA, 16'h0000, 1'b0);
    send(16'h0400, 1'b0, 4'hB, 16'h0000, 1'b0);
    send(16'hFC00, 1'b0, 4'hC, 16'h0000, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_out_valid", out_valid, 0);
    reset = 1'b0;
    repeat (8) @(negedge clock);
    send(16'hFF80, 1'b0, 4'h7, 16'hFF8A, 1'b1);
    measure_latency("post_rst_latency");
    drain();

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwq_activation.md
Name: pwq_activation

Overview:
- Pipelined, parametrised piecewise-quadratic activation unit for the LSTM datapath.
- Per transaction, selects tanh or sigmoid; sigmoid is computed as 0.5 + 0.5*tanh(x/2) on the shared tanh tables.
- Valid/ready handshake with full back-pressure, plus an opaque tag carried alongside the data.
- Sits between the gate MAC accumulators and the cell-state update logic.

Parameters:
- DATA_W, 16, signed two's-complement data width of in_data/out_data.
- FRAC_W, 8, fractional bits; 1.0 = 1<<FRAC_W.
- TAG_W, 4, width of the sideband tag carried with each sample.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  reset (see Behaviour)
- in_valid  in  1  input sample valid
- in_ready  out  1  unit accepts a sample this cycle
- in_data  in  DATA_W  signed fixed-point x
- in_mode  in  1  0 = tanh, 1 = sigmoid
- in_tag  in  TAG_W  sideband, returned unchanged
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  DATA_W  signed fixed-point result
- out_tag  out  TAG_W  tag of the result

Behaviour:
- reset reset, synchronous, active-high; clock clock.
- On reset, all stage valid bits clear, out_valid=0, out_data=0, out_tag=0. A reset mid-operation discards all in-flight samples.
- Pipeline: 4 stages S1..S4, each with its own valid bit.
  - advance = !out_valid || out_ready.
  - All stages shift together when advance=1 and hold when advance=0.
  - in_ready = advance (combinational).
  - A sample transfers when in_valid && in_ready.
- Latency: a sample accepted at edge N gives out_valid=1 after edge N+4 with no stall. Throughput is 1 per cycle. Bubbles propagate as invalid stages.
- S1:
  - xe = in_mode ? (in_data >>> 1) : in_data.
  - Segment compare on xe, with strict boundaries:
    - xe <= -3 → SAT_NEG
    - -3 < xe <= -1 → SEG0
    - -1 < xe <= 0 → SEG1
    - 0 < xe <= 1 → SEG2
    - 1 < xe <= 3 → SEG3
    - xe > 3 → SAT_POS
  - Register xe, mode, tag, and coefficients (c0, c1, c2) from the package table.
  - SAT_NEG: c1=c2=0, c0=-1.0. SAT_POS: c1=c2=0, c0=+1.0.
- S2: sq = (xe*xe) >>> FRAC_W; p1 = (c1*xe) >>> FRAC_W. Products are full 2*DATA_W signed.
- S3: p2 = (c2*sq) >>> FRAC_W; carry c0 and p1 forward.
- S4:
  - t = c0 + p1 + p2, computed in DATA_W+2 bits.
  - Clamp t to [-(1<<FRAC_W), +(1<<FRAC_W)].
  - Sigmoid: out = (1<<(FRAC_W-1)) + (t >>> 1). Tanh: out = t.
- Shifts are arithmetic floor unless the optional feature is enabled.
- A simultaneous accept and output handshake in the same cycle is legal and required for full rate.

Optional Feature:
- Macro PWQ_ROUND_EN.
  - Defined: every >>> FRAC_W product scaling adds 1<<(FRAC_W-1) before the shift (round half up).
  - Undefined: truncation (floor).
- Latency, handshake and clamp behaviour are identical in both builds.

Decomposition:
- Shared package pwq_pkg holds:
  - Segment enum: SAT_NEG, SEG0..SEG3, SAT_POS.
  - Real-valued coefficient table for tanh: SEG0 (-0.39814608, 0.46527859, 0.09007576); SEG1 (0.0031444, 1.08381219, 0.31592922); SEG2 (-0.00349517, 1.08538355, -0.31676793); SEG3 (0.39878032, 0.46509003, -0.09013554).
  - An elaboration-time function quantising each coefficient to round(c * 2^FRAC_W).
- One sub-module: pwq_seg_select, the S1 compare plus coefficient mux, combinational, parametrised by DATA_W/FRAC_W.

Test Plan (defaults, no PWQ_ROUND_EN):
- tanh, x=0x0100 (1.0), out_ready=1 → 4 cycles later out_data=196 (0x00C4): 278 - 81 - 1.
- Boundaries, tanh: x=0x0400 → 0x0100; x=0xFC00 → 0xFF00; x=0xFD00 (-3.0 exactly) → 0xFF00; x=0 → 0x0001.
- Sigmoid: x=0 → 0x0080; x=0x0800 (8.0) → 0x0100; x=0xF800 → 0x0000.
- Streaming: 16 back-to-back samples with alternating modes and tags 0..15 → 16 results in order, tags match, one per cycle.
- Back-pressure: hold out_ready=0 for 6 cycles mid-stream → out_data/out_tag stable, in_ready=0 while out_valid=1, no sample lost or duplicated.
- Assert reset with 3 samples in flight → next cycle out_valid=0; first post-reset sample completes with 4-cycle latency.
